fifo_flex: RTL and testbench

Parametrised synchronous single-clock FIFO, next generation of the team's basic FIFO. Adds a selectable read mode (standard registered read or first-word-fall-through), an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and an accepted read-and-write when full. Drop-in buffer between producer/consumer blocks in the minilab datapaths.

---
 rtl/fifo_flex_pkg.sv | 13 +
 rtl/fifo_flex_if.sv | 31 +++
 rtl/fifo_flex_mem.sv | 20 ++
 rtl/fifo_flex.sv | 100 ++++++++++
 tb/tb_fifo_flex.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fifo_flex_pkg.sv
// Shared types and parameter legality check for the flexible FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  // DEPTH must be a power of two >= 2; thresholds must sit inside the occupancy range.
  function automatic bit fifo_params_ok(input int depth, input int afull, input int aempty);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull >= 1) && (afull <= depth) &&
           (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Producer/consumer bus of fifo_flex: master drives requests, slave (the FIFO) drives status.
interface fifo_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  wren;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  rden;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wren, i_data, rden, clr_err,
    input  o_data, o_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wren, i_data, rden, clr_err,
    output o_data, o_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flex_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH registers, synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
)(
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO with STD/FWFT read modes, occupancy count, almost flags and sticky errors.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         DEPTH         = 8,
  parameter fifo_mode_e MODE          = FIFO_STD,
  parameter int         AFULL_THRESH  = DEPTH - 2,
  parameter int         AEMPTY_THRESH = 2
)(
  input logic        clk,
  input logic        rst_n,
  fifo_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AEMPTY_THRESH);

  if (!fifo_params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
    $error("fifo_flex: illegal DEPTH or threshold parameters");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Extra pointer bit makes full (cnt == DEPTH) distinguishable from empty.
  assign cnt    = wr_ptr_q - rd_ptr_q;
  assign full   = (cnt == DEPTH_C);
  assign empty  = (cnt == '0);
  assign rd_acc = bus.rden & ~empty;
  assign wr_acc = bus.wren & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d    = rd_ptr_q + PW'(rd_acc);
    overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wren & ~wr_acc);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.rden & empty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // On full with a concurrent read, wr_ptr aliases rd_ptr: the old head is read out
  // asynchronously before the edge, the new word lands in the freed slot.
  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc & rst_n),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.i_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        o_data_q  <= '0;
        o_valid_q <= 1'b0;
      end else begin
        o_valid_q <= rd_acc;
        if (rd_acc) o_data_q <= rdata;
      end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
  end else begin : g_fwft
    assign bus.o_data  = rdata;
    assign bus.o_valid = ~empty;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt >= AF_C);
  assign bus.almost_empty = (cnt <= AE_C);
  assign bus.count        = cnt;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flex.sv
// Runs a STD and a FWFT fifo_flex side by side on identical stimulus against a queue model.
module tb_fifo_flex;
  import fifo_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] last;
  logic       ovf, unf;

  fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(8)) bs ();
  fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(8)) bf ();

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .MODE(FIFO_STD)) u_std (
    .clk(clk), .rst_n(rst_n), .bus(bs));
  fifo_flex #(.DATA_WIDTH(8), .DEPTH(8), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    bs.wren = w; bs.i_data = d; bs.rden = r; bs.clr_err = c;
    bf.wren = w; bf.i_data = d; bf.rden = r; bf.clr_err = c;
  endtask

  task automatic chk_flags(input string p, input logic fl, input logic em, input logic af,
                           input logic ae, input logic [3:0] cnt, input logic ov, input logic un);
    int n;
    n = mq.size();
    chk({p, ".count"}, cnt, n);
    chk({p, ".full"}, fl, n == 8);
    chk({p, ".empty"}, em, n == 0);
    chk({p, ".almost_full"}, af, n >= 6);
    chk({p, ".almost_empty"}, ae, n <= 2);
    chk({p, ".overflow"}, ov, ovf);
    chk({p, ".underflow"}, un, unf);
  endtask

  task automatic check_all(input logic racc);
    chk_flags("std", bs.full, bs.empty, bs.almost_full, bs.almost_empty, bs.count, bs.overflow, bs.underflow);
    chk_flags("fwft", bf.full, bf.empty, bf.almost_full, bf.almost_empty, bf.count, bf.overflow, bf.underflow);
    chk("std.o_valid", bs.o_valid, racc);
    chk("std.o_data", bs.o_data, last);
    if (bs.o_valid && exp_q.size() > 0) chk("std.sb", bs.o_data, exp_q.pop_front());
    chk("fwft.o_valid", bf.o_valid, mq.size() != 0);
    if (mq.size() != 0) chk("fwft.o_data", bf.o_data, mq[0]);
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic me, mf, racc, wacc;
    @(negedge clk);
    rst_n = 1'b1;
    drive(w, d, r, c);
    @(posedge clk);
    me   = (mq.size() == 0);
    mf   = (mq.size() == 8);
    racc = r & ~me;
    wacc = w & (~mf | racc);
    if (racc) begin
      last = mq.pop_front();
      exp_q.push_back(last);
    end
    if (wacc) mq.push_back(d);
    ovf = (ovf & ~c) | (w & ~wacc);
    unf = (unf & ~c) | (r & me);
    #1;
    check_all(racc);
  endtask

  task automatic do_reset(input logic w, input logic r);
    @(negedge clk);
    rst_n = 1'b0;
    drive(w, 8'hEE, r, 1'b0);
    @(posedge clk);
    mq.delete();
    exp_q.delete();
    ovf = 1'b0; unf = 1'b0; last = 8'h00;
    #1;
    check_all(1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    ovf = 1'b0; unf = 1'b0; last = 8'h00;
    do_reset(1'b0, 1'b0);
    do_reset(1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Read and write together while full.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Read and write together while empty, then error-clear interplay.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT presentation and pop sequence (checked on both instances).
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-operation with requests asserted.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Pointer wrap with order preserved.
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h80 + i), i > 2, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random mix.
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    chk("std.sb_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
